// File: rtl/pdm_audio_out.sv
// ---------------------------------------------------------------------------
// pdm_audio_out
//
// Audio output stage. Accepts 16-bit signed samples over a valid/ready
// handshake, releases one sample per SAMPLE_PERIOD clocks, and drives a
// first-order sigma-delta (PDM) bit stream to the board audio pin. Sample
// slots that arrive with no sample available are counted as underruns.
//
// Handshake: a sample transfers on any clk_in edge where sample_valid_in and
// sample_ready_out are both 1. While sample_ready_out is 0 the upstream
// source must hold sample_in and sample_valid_in stable; a valid without
// ready is ignored.
//
// Optional feature macro: PDM_AUDIO_OUT_SOFT_MUTE_EN
//   undefined : mute_in hard-mutes (next active sample forced to 0 at a tick)
//   defined   : mute_in drives a gain ramp FSM (256 ticks full-scale to 0)
//
// Parameters
//   SAMPLE_PERIOD       clk_in cycles per output sample (>= 2)
//   UNDERRUN_W          width of the saturating underrun counter
//
// Ports
//   clk_in              system clock
//   rst_in              synchronous reset, active-low
//   sample_in           signed two's-complement audio sample
//   sample_valid_in     sample_in is valid
//   sample_ready_out    block can accept a sample this cycle
//   mute_in             level-sensitive mute request, sampled at ticks
//   sample_tick_out     one-cycle pulse at each sample boundary
//   pdm_out             registered PDM bit stream
//   underrun_count_out  saturating count of empty sample slots
//   mute_state_out      (soft mute only) gain FSM state, debug
//   mute_gain_out       (soft mute only) current gain 0..256, debug
// ---------------------------------------------------------------------------
module pdm_audio_out #(
    parameter int SAMPLE_PERIOD = 2268,
    parameter int UNDERRUN_W    = 16
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [15:0]           sample_in,
    input  logic                  sample_valid_in,
    output logic                  sample_ready_out,
    input  logic                  mute_in,
    output logic                  sample_tick_out,
    output logic                  pdm_out,
`ifdef PDM_AUDIO_OUT_SOFT_MUTE_EN
    output logic [1:0]            mute_state_out,
    output logic [8:0]            mute_gain_out,
`endif
    output logic [UNDERRUN_W-1:0] underrun_count_out
);

    localparam int CNT_W = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  tick_q, tick_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [15:0]           pend_data_q, pend_data_d;
    logic [15:0]           active_q, active_d;
    logic [UNDERRUN_W-1:0] under_q, under_d;
    logic [15:0]           acc_q, acc_d;
    logic                  pdm_q, pdm_d;

    logic                  xfer;
    logic                  load;
    logic [15:0]           load_val;
    logic [15:0]           mod_sample;
    logic [15:0]           mod_u;
    logic [16:0]           mod_sum;

    // ------------------------------------------------------------------
    // Tick counter, input buffer, active sample, underrun counter
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d        = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        // Registered tick: high exactly while the counter sits at its last value.
        tick_d       = (cnt_d == CNT_LAST);
        xfer         = sample_valid_in && !pend_valid_q;
        pend_valid_d = pend_valid_q;
        pend_data_d  = pend_data_q;
        under_d      = under_q;
        load         = 1'b0;
        load_val     = pend_data_q;

        if (tick_q) begin
            if (pend_valid_q) begin
                load         = 1'b1;
                load_val     = pend_data_q;
                pend_valid_d = 1'b0;
            end else if (xfer) begin
                // Sample arriving on the tick bypasses the buffer.
                load     = 1'b1;
                load_val = sample_in;
            end else if (under_q != '1) begin
                under_d = under_q + UNDERRUN_W'(1);
            end
        end else if (xfer) begin
            pend_valid_d = 1'b1;
            pend_data_d  = sample_in;
        end

`ifdef PDM_AUDIO_OUT_SOFT_MUTE_EN
        active_d = load ? load_val : active_q;
`else
        active_d = load ? (mute_in ? 16'h0000 : load_val) : active_q;
`endif
    end

`ifdef PDM_AUDIO_OUT_SOFT_MUTE_EN
    // ------------------------------------------------------------------
    // Soft-mute gain FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        UNMUTED   = 2'd0,
        RAMP_DOWN = 2'd1,
        MUTED     = 2'd2,
        RAMP_UP   = 2'd3
    } gain_state_t;

    gain_state_t state_q, state_d;
    logic [8:0]  g_q, g_d;
    logic signed [25:0] gain_prod;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q <= UNMUTED;
            g_q     <= 9'd256;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
        end
    end

    // A change of mute_in mid-ramp only flips the direction; g carries over.
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        if (tick_q) begin
            case (state_q)
                UNMUTED: if (mute_in) state_d = RAMP_DOWN;
                RAMP_DOWN: begin
                    if (!mute_in) begin
                        state_d = RAMP_UP;
                    end else if (g_q == 9'd0) begin
                        state_d = MUTED;
                    end else begin
                        g_d = g_q - 9'd1;
                        if (g_q == 9'd1) state_d = MUTED;
                    end
                end
                MUTED: if (!mute_in) state_d = RAMP_UP;
                RAMP_UP: begin
                    if (mute_in) begin
                        state_d = RAMP_DOWN;
                    end else if (g_q >= 9'd256) begin
                        state_d = UNMUTED;
                    end else begin
                        g_d = g_q + 9'd1;
                        if (g_q == 9'd255) state_d = UNMUTED;
                    end
                end
                default: state_d = UNMUTED;
            endcase
        end
    end

    // Effective sample = (active * g) >>> 8, truncated to 16 bits.
    always_comb begin
        gain_prod      = $signed({{10{active_q[15]}}, active_q}) * $signed({17'd0, g_q});
        mod_sample     = gain_prod[23:8];
        mute_state_out = state_q;
        mute_gain_out  = g_q;
    end
`else
    always_comb begin
        mod_sample = active_q;
    end
`endif

    // ------------------------------------------------------------------
    // First-order sigma-delta: carry out of acc + offset-binary sample
    // ------------------------------------------------------------------
    always_comb begin
        mod_u   = mod_sample ^ 16'h8000;
        mod_sum = {1'b0, acc_q} + {1'b0, mod_u};
        acc_d   = mod_sum[15:0];
        pdm_d   = mod_sum[16];
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            cnt_q        <= '0;
            tick_q       <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_data_q  <= 16'h0000;
            active_q     <= 16'h0000;
            under_q      <= '0;
            acc_q        <= 16'h0000;
            pdm_q        <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            tick_q       <= tick_d;
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
            active_q     <= active_d;
            under_q      <= under_d;
            acc_q        <= acc_d;
            pdm_q        <= pdm_d;
        end
    end

    assign sample_ready_out   = !pend_valid_q;
    assign sample_tick_out    = tick_q;
    assign pdm_out            = pdm_q;
    assign underrun_count_out = under_q;

endmodule

// File: tb/tb_pdm_audio_out.sv
// ---------------------------------------------------------------------------
// tb_pdm_audio_out
//
// Bench for pdm_audio_out with SAMPLE_PERIOD=8, UNDERRUN_W=4. A reference
// model tracks elapsed cycles since reset, a one-entry sample buffer and the
// cumulative sum of offset-binary samples; the PDM bit of a cycle is the
// change in that sum's 65536s digit. The model pushes the expected
// {tick, ready, pdm, underrun} word per clock edge; a monitor pops and
// compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_pdm_audio_out;

    localparam int P  = 8;
    localparam int UW = 4;
    localparam int W  = 3 + UW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   sample = 16'h0000;
    logic          valid = 1'b0;
    logic          ready;
    logic          mute = 1'b0;
    logic          tick;
    logic          pdm;
    logic [UW-1:0] under;

    logic [W-1:0]  exp_q[$];
    int            total = 0;
    int            passed = 0;

    pdm_audio_out #(
        .SAMPLE_PERIOD(P),
        .UNDERRUN_W   (UW)
    ) dut (
        .clk_in            (clk),
        .rst_in            (rst_n),
        .sample_in         (sample),
        .sample_valid_in   (valid),
        .sample_ready_out  (ready),
        .mute_in           (mute),
        .sample_tick_out   (tick),
        .pdm_out           (pdm),
        .underrun_count_out(under)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    initial begin
        longint unsigned k;
        bit              pv;
        logic [15:0]     pd;
        logic [15:0]     act;
        int              und;
        longint unsigned s;
        longint unsigned s_new;
        bit              tick_now;
        bit              xfer;
        bit              pdm_e;
        logic [UW-1:0]   und_v;
        k = 0; pv = 0; pd = 0; act = 0; und = 0; s = 0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                k = 0; pv = 0; act = 0; und = 0; s = 0;
                exp_q.push_back({1'b0, 1'b1, 1'b0, {UW{1'b0}}});
            end else begin
                tick_now = ((k % P) == P - 1);
                xfer     = valid && !pv;
                s_new    = s + longint'(act ^ 16'h8000);
                pdm_e    = ((s_new >> 16) != (s >> 16));
                s        = s_new;
                if (tick_now) begin
                    if (pv) begin
                        act = mute ? 16'h0000 : pd;
                        pv  = 0;
                    end else if (xfer) begin
                        act = mute ? 16'h0000 : sample;
                    end else if (und < (1 << UW) - 1) begin
                        und = und + 1;
                    end
                end else if (xfer) begin
                    pv = 1;
                    pd = sample;
                end
                k = k + 1;
                und_v = UW'(und);
                exp_q.push_back({((k % P) == P - 1), !pv, pdm_e, und_v});
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [W-1:0] e;
        logic [W-1:0] got;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                if (total > 0) begin
                    total = total + 1;
                    $display("FAIL sb_empty: no expected entry at %0t", $time);
                end
            end else begin
                e   = exp_q.pop_front();
                got = {tick, ready, pdm, under};
                total = total + 1;
                if (got === e) begin
                    passed = passed + 1;
                end else begin
                    $display("FAIL outputs at %0t: got tick=%0b ready=%0b pdm=%0b under=%0d, expected tick=%0b ready=%0b pdm=%0b under=%0d",
                             $time, got[W-1], got[W-2], got[W-3], got[UW-1:0],
                             e[W-1], e[W-2], e[W-3], e[UW-1:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        valid = 1'b0;
        repeat (n) cyc();
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [15:0] d);
        int b;
        b      = 0;
        sample = d;
        valid  = 1'b1;
        while (!ready && b < 100) begin
            cyc();
            b++;
        end
        if (b >= 100) begin
            total = total + 1;
            $display("FAIL send_timeout: ready=%0b after %0d cycles, expected 1", ready, b);
        end
        cyc();
        valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int b;
        do_reset(3);

        // Idle: 0/1 alternation, ticks every 8 cycles, underrun saturates at 15.
        idle(150);

        // Single full-scale sample then starvation.
        do_reset(2);
        send(16'h7FFF);
        idle(1100);

        // Random samples, gaps and mute.
        do_reset(2);
        for (int i = 0; i < 60; i++) begin
            idle($urandom_range(0, 12));
            mute = ($urandom_range(0, 3) == 0);
            send(16'($urandom));
        end
        mute = 1'b0;

        // Continuous streams: negative full scale, then 0x4000.
        for (int i = 0; i < 20; i++) send(16'h8000);
        for (int i = 0; i < 20; i++) send(16'h4000);
        idle(20);

        // Sample offered exactly on the tick cycle with the buffer empty.
        do_reset(2);
        b = 0;
        while (!tick && b < 100) begin
            cyc();
            b++;
        end
        if (b >= 100) begin
            total = total + 1;
            $display("FAIL tick_timeout: tick=%0b after %0d cycles, expected 1", tick, b);
        end
        sample = 16'h1234;
        valid  = 1'b1;
        cyc();
        valid  = 1'b0;
        idle(30);

        // Reset mid-stream with active=0x7FFF and buffer full.
        send(16'h7FFF);
        idle(10);
        send(16'h7FFF);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        idle(30);

        @(negedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
